// File: rtl/motor_step_ramp_if.sv
// ---------------------------------------------------------------------------
// motor_step_ramp_if
//   Move-command handshake between the command sequencer (master) and the
//   step/dir ramp generator (slave).
//
//   cmd_valid      master -> slave  command present
//   cmd_ready      slave  -> master generator idle, can accept a command
//   cmd_steps      master -> slave  number of steps to issue
//   cmd_dir        master -> slave  direction (1 = position increments)
//   cmd_div        master -> slave  cruise (minimum) step period, CLK cycles
//   cmd_start_div  master -> slave  initial/final step period, CLK cycles
//   cmd_accel      master -> slave  period change per step, 0 = no ramp
// ---------------------------------------------------------------------------
interface motor_step_ramp_if #(
  parameter int DIV_W   = 16,
  parameter int STEPS_W = 16
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [STEPS_W-1:0] cmd_steps;
  logic               cmd_dir;
  logic [DIV_W-1:0]   cmd_div;
  logic [DIV_W-1:0]   cmd_start_div;
  logic [DIV_W-1:0]   cmd_accel;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_dir,
    output cmd_div,
    output cmd_start_div,
    output cmd_accel,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_dir,
    input  cmd_div,
    input  cmd_start_div,
    input  cmd_accel,
    output cmd_ready
  );

endinterface

// File: rtl/motor_step_ramp.sv
// ---------------------------------------------------------------------------
// motor_step_ramp
//   Single-axis step/dir generator with a linear period ramp
//   (accelerate / cruise / decelerate), a direction-setup delay and a
//   signed absolute position counter.
//
//   Optional feature macro: STEP_ABORT_EN
//     defined   : abort_i requests a controlled stop (ramp down, then done)
//     undefined : abort_i is ignored
//
// Ports
//   CLK         system clock
//   reset       synchronous, active-high reset
//   cmd         move-command handshake (motor_step_ramp_if.slave)
//   pos_clr_i   clear position counter (wins over a coincident step)
//   abort_i     controlled stop request
//   dir_o       driver direction
//   step_o      driver step pulse
//   busy_o      high in DIR_SETUP and RUN
//   done_o      one-cycle pulse at move completion
//   position_o  signed absolute position, two's-complement wrap
//
// State     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a command, cmd_ready high
// DIR_SETUP | direction just changed, holding off the first step
// RUN       | emitting steps along the period ramp
// ---------------------------------------------------------------------------
module motor_step_ramp #(
  parameter int DIV_W         = 16,
  parameter int STEPS_W       = 16,
  parameter int POS_W         = 24,
  parameter int DIR_SETUP_CYC = 255
) (
  input  logic                    CLK,
  input  logic                    reset,
  motor_step_ramp_if.slave        cmd,
  input  logic                    pos_clr_i,
  input  logic                    abort_i,
  output logic                    dir_o,
  output logic                    step_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic signed [POS_W-1:0] position_o
);

  // The setup counter is loaded with DIR_SETUP_CYC-1 and RUN is entered on
  // the edge that sees zero, so the first step rises DIR_SETUP_CYC+1 cycles
  // after the accepting edge.
  localparam int DLY_W = (DIR_SETUP_CYC > 2) ? $clog2(DIR_SETUP_CYC) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD =
    DLY_W'((DIR_SETUP_CYC > 0) ? DIR_SETUP_CYC - 1 : 0);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIR_SETUP = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   start_div_q;
  logic [DIV_W-1:0]   accel_q;
  logic [DIV_W-1:0]   cur_div_q;
  logic [DIV_W-1:0]   cnt_q;
  logic [DIV_W-1:0]   half_q;
  logic [STEPS_W-1:0] steps_left_q;
  logic [STEPS_W-1:0] ramp_cnt_q;
  logic [DLY_W-1:0]   delay_q;
  logic [POS_W-1:0]   position_q;
  logic               dir_q;
  logic               step_q;
  logic               done_q;
  logic               zero_pend_q;

  logic               accept;
  logic               accept_move;
  logic               emit;
  logic               finish;
  logic               abort_run;
  logic               abort_setup;

  logic [DIV_W-1:0]   div_cl;
  logic [DIV_W-1:0]   start_raw;
  logic [DIV_W-1:0]   start_cl;

  logic [STEPS_W-1:0] steps_dec;
  logic [STEPS_W-1:0] steps_left_d;
  logic [STEPS_W-1:0] ramp_cnt_d;
  logic [DIV_W-1:0]   cur_div_d;
  logic [DIV_W:0]     ramp_sum;
  logic [DIV_W:0]     ramp_diff;

`ifdef STEP_ABORT_EN
  assign abort_run   = abort_i && (state_q == ST_RUN);
  assign abort_setup = abort_i && (state_q == ST_DIR_SETUP);
`else
  logic unused_abort;
  assign unused_abort = abort_i;
  assign abort_run    = 1'b0;
  assign abort_setup  = 1'b0;
`endif

  assign accept      = cmd.cmd_valid && (state_q == ST_IDLE);
  assign accept_move = accept && (cmd.cmd_steps != '0);
  assign emit        = (state_q == ST_RUN) && (cnt_q == '0) && (steps_left_q != '0);
  assign finish      = (state_q == ST_RUN) && (cnt_q == '0) && (steps_left_q == '0);

  // Period clamp applied to the incoming command.
  always_comb begin
    div_cl    = (cmd.cmd_div < DIV_MIN) ? DIV_MIN : cmd.cmd_div;
    start_raw = (cmd.cmd_start_div < DIV_MIN) ? DIV_MIN : cmd.cmd_start_div;
    start_cl  = (start_raw < div_cl) ? div_cl : start_raw;
  end

  // Ramp step, evaluated against the post-decrement step count. An abort
  // arriving on an emission edge trims the remaining count before the
  // decision so the deceleration starts with this very step.
  always_comb begin
    steps_dec    = steps_left_q - STEPS_W'(1);
    steps_left_d = (abort_run && (steps_dec > ramp_cnt_q)) ? ramp_cnt_q : steps_dec;
    ramp_sum     = {1'b0, cur_div_q} + {1'b0, accel_q};
    ramp_diff    = {1'b0, cur_div_q} - {1'b0, accel_q};
    cur_div_d    = cur_div_q;
    ramp_cnt_d   = ramp_cnt_q;
    if (steps_left_d <= ramp_cnt_q) begin
      cur_div_d  = (ramp_sum > {1'b0, start_div_q}) ? start_div_q : ramp_sum[DIV_W-1:0];
      ramp_cnt_d = (ramp_cnt_q != '0) ? ramp_cnt_q - STEPS_W'(1) : '0;
    end else if (cur_div_q > div_q) begin
      // Top bit set means the subtraction borrowed.
      cur_div_d  = (ramp_diff[DIV_W] || (ramp_diff[DIV_W-1:0] < div_q)) ?
                   div_q : ramp_diff[DIV_W-1:0];
      ramp_cnt_d = ramp_cnt_q + STEPS_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_move) begin
          if ((cmd.cmd_dir != dir_q) && (DIR_SETUP_CYC != 0)) begin
            state_d = ST_DIR_SETUP;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DIR_SETUP: begin
        if (abort_setup) begin
          state_d = ST_IDLE;
        end else if (delay_q == '0) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (finish) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd.cmd_ready = (state_q == ST_IDLE);
    busy_o        = (state_q != ST_IDLE);
  end

  // Datapath: command latch, step timer, ramp and position.
  always_ff @(posedge CLK) begin
    if (reset) begin
      div_q        <= '0;
      start_div_q  <= '0;
      accel_q      <= '0;
      cur_div_q    <= '0;
      cnt_q        <= '0;
      half_q       <= '0;
      steps_left_q <= '0;
      ramp_cnt_q   <= '0;
      delay_q      <= '0;
      position_q   <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      done_q       <= 1'b0;
      zero_pend_q  <= 1'b0;
    end else begin
      // A zero-step command completes one edge after it is accepted.
      zero_pend_q <= accept && (cmd.cmd_steps == '0);
      done_q      <= zero_pend_q || finish || abort_setup;

      if (accept_move) begin
        div_q        <= div_cl;
        start_div_q  <= start_cl;
        accel_q      <= cmd.cmd_accel;
        cur_div_q    <= (cmd.cmd_accel == '0) ? div_cl : start_cl;
        ramp_cnt_q   <= '0;
        cnt_q        <= '0;
        steps_left_q <= cmd.cmd_steps;
        delay_q      <= DLY_LOAD;
        dir_q        <= cmd.cmd_dir;
      end

      if (state_q == ST_DIR_SETUP) begin
        delay_q <= delay_q - DLY_W'(1);
        step_q  <= 1'b0;
      end

      if (emit) begin
        step_q       <= 1'b1;
        cnt_q        <= cur_div_q - DIV_W'(1);
        half_q       <= cur_div_q >> 1;
        steps_left_q <= steps_left_d;
        cur_div_q    <= cur_div_d;
        ramp_cnt_q   <= ramp_cnt_d;
      end else if (state_q == ST_RUN) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - DIV_W'(1);
          if (cnt_q == half_q) begin
            step_q <= 1'b0;
          end
        end else begin
          step_q <= 1'b0;
        end
        if (abort_run && (steps_left_q > ramp_cnt_q)) begin
          steps_left_q <= ramp_cnt_q;
        end
      end

      if (pos_clr_i) begin
        position_q <= '0;
      end else if (emit) begin
        position_q <= dir_q ? position_q + POS_W'(1) : position_q - POS_W'(1);
      end
    end
  end

  assign dir_o      = dir_q;
  assign step_o     = step_q;
  assign done_o     = done_q;
  assign position_o = $signed(position_q);

endmodule

// File: tb/tb_motor_step_ramp.sv
`timescale 1ns/1ps
module tb_motor_step_ramp;

  localparam int POS_W = 6;
  localparam int NV    = 9;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic pos_clr_i = 1'b0;
  logic abort_i = 1'b0;
  logic dir_o, step_o, busy_o, done_o;
  logic signed [POS_W-1:0] position_o;

  motor_step_ramp_if #(.DIV_W(16), .STEPS_W(16)) cif ();

  motor_step_ramp #(
    .DIV_W(16), .STEPS_W(16), .POS_W(POS_W), .DIR_SETUP_CYC(255)
  ) dut (
    .CLK(CLK), .reset(reset), .cmd(cif), .pos_clr_i(pos_clr_i), .abort_i(abort_i),
    .dir_o(dir_o), .step_o(step_o), .busy_o(busy_o), .done_o(done_o),
    .position_o(position_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int steps; int dir; int dv; int sd; int ac;
    int first; int high; int p[10];
  } vec_t;

  vec_t tv[NV];
  int n_pass = 0;
  int n_tot = 0;
  int rises[128];
  int nr, done_n, first_high, pos_at_clr, done_at0, dir_at0, rdy_at_issue;
  logic [POS_W-1:0] pos_exp;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int per(input int k);
    if (k < nr - 1) return rises[k+1] - rises[k];
    if (k == nr - 1 && done_n > 0) return done_n - rises[k];
    return -1;
  endfunction

  // Issue one command at a negedge and watch until done or budget expiry.
  // Edge 0 is the accepting edge; sample n is taken at the negedge after edge n.
  task automatic run_move(input int steps, input int d, input int dv, input int sd,
                          input int ac, input int abort_at, input int clr_at,
                          input int budget);
    logic prev, hi_done;
    nr = 0; done_n = -1; first_high = 0; pos_at_clr = -999; hi_done = 1'b0;
    rises[0] = -1;
    cif.cmd_valid = 1'b1;
    cif.cmd_steps = 16'(steps);
    cif.cmd_dir = (d != 0);
    cif.cmd_div = 16'(dv);
    cif.cmd_start_div = 16'(sd);
    cif.cmd_accel = 16'(ac);
    rdy_at_issue = int'(cif.cmd_ready);
    @(negedge CLK);
    cif.cmd_valid = 1'b0;
    done_at0 = int'(done_o);
    dir_at0 = int'(dir_o);
    prev = step_o;
    for (int n = 1; n <= budget; n++) begin
      abort_i = (n - 1 == abort_at);
      pos_clr_i = (n - 1 == clr_at);
      @(negedge CLK);
      if (step_o && !prev) begin
        if (nr < 128) rises[nr] = n;
        nr++;
      end
      if (nr == 1 && step_o && !hi_done) first_high++;
      if (nr >= 1 && !step_o) hi_done = 1'b1;
      if (n == clr_at + 1) pos_at_clr = int'(position_o);
      prev = step_o;
      if (done_o) begin
        done_n = n;
        break;
      end
    end
    abort_i = 1'b0;
    pos_clr_i = 1'b0;
  endtask

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_steps = '0; cif.cmd_dir = 1'b0;
    cif.cmd_div = '0; cif.cmd_start_div = '0; cif.cmd_accel = '0;
    pos_exp = '0;

    //            steps dir dv  sd  ac  first high periods
    tv[0] = '{1,  1, 10, 10, 0,   256, 5,  '{10,0,0,0,0,0,0,0,0,0}};
    tv[1] = '{4,  1, 10, 10, 0,   1,   5,  '{10,10,10,10,0,0,0,0,0,0}};
    tv[2] = '{10, 1, 8,  20, 4,   1,   10, '{20,16,12,8,8,8,8,12,16,20}};
    tv[3] = '{3,  1, 0,  1,  0,   1,   1,  '{2,2,2,0,0,0,0,0,0,0}};
    tv[4] = '{3,  1, 6,  3,  2,   1,   3,  '{6,6,6,0,0,0,0,0,0,0}};
    tv[5] = '{5,  1, 4,  20, 5,   1,   10, '{20,15,10,15,20,0,0,0,0,0}};
    tv[6] = '{4,  1, 2,  10, 100, 1,   5,  '{10,2,2,10,0,0,0,0,0,0}};
    tv[7] = '{3,  1, 2,  12, 65535, 1, 6,  '{12,2,12,0,0,0,0,0,0,0}};
    tv[8] = '{1,  0, 10, 10, 0,   256, 5,  '{10,0,0,0,0,0,0,0,0,0}};

    repeat (3) @(negedge CLK);
    chk("reset step", int'(step_o), 0);
    chk("reset busy", int'(busy_o), 0);
    chk("reset done", int'(done_o), 0);
    chk("reset dir", int'(dir_o), 0);
    chk("reset position", int'(position_o), 0);
    chk("reset ready", int'(cif.cmd_ready), 1);
    reset = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < NV; i++) begin
      run_move(tv[i].steps, tv[i].dir, tv[i].dv, tv[i].sd, tv[i].ac, -1, -1, 800);
      chk($sformatf("v%0d ready", i), rdy_at_issue, 1);
      chk($sformatf("v%0d dir at accept", i), dir_at0, tv[i].dir);
      chk($sformatf("v%0d done seen", i), int'(done_n > 0), 1);
      chk($sformatf("v%0d step count", i), nr, tv[i].steps);
      chk($sformatf("v%0d first rise", i), rises[0], tv[i].first);
      chk($sformatf("v%0d high time", i), first_high, tv[i].high);
      for (int k = 0; k < tv[i].steps && k < 10; k++)
        chk($sformatf("v%0d period %0d", i, k), per(k), tv[i].p[k]);
      pos_exp = (tv[i].dir != 0) ? pos_exp + POS_W'(tv[i].steps) : pos_exp - POS_W'(tv[i].steps);
      chk($sformatf("v%0d position", i), int'(position_o), int'($signed(pos_exp)));
    end

    // Zero-step command: done one edge after accept, dir unchanged (currently 0).
    run_move(0, 1, 10, 10, 0, -1, -1, 20);
    chk("zero ready", rdy_at_issue, 1);
    chk("zero done at accept", done_at0, 0);
    chk("zero done edge", done_n, 1);
    chk("zero no step", nr, 0);
    chk("zero dir kept", int'(dir_o), 0);
    chk("zero position", int'(position_o), int'($signed(pos_exp)));
    @(negedge CLK);
    chk("zero done one cycle", int'(done_o), 0);
    chk("zero busy", int'(busy_o), 0);

    // Position wrap at +2^(POS_W-1)-1.
    pos_clr_i = 1'b1;
    @(negedge CLK);
    pos_clr_i = 1'b0;
    chk("pos_clr idle", int'(position_o), 0);
    run_move(31, 1, 2, 2, 0, -1, -1, 800);
    chk("wrap pre count", nr, 31);
    chk("wrap pre position", int'(position_o), 31);
    run_move(1, 1, 2, 2, 0, -1, -1, 50);
    chk("wrap position", int'(position_o), -32);

    // pos_clr coincident with the second step rise (edge 11).
    run_move(3, 1, 10, 10, 0, -1, 10, 200);
    chk("clr second rise", rises[1], 11);
    chk("clr coincident position", pos_at_clr, 0);
    chk("clr final position", int'(position_o), 1);

`ifdef STEP_ABORT_EN
    // Abort coincident with the 5th emission edge (57): 3 more steps 12,16,20.
    run_move(100, 1, 8, 20, 4, 56, -1, 400);
    chk("abort step count", nr, 8);
    chk("abort 5th rise", rises[4], 57);
    chk("abort period 5", per(5), 12);
    chk("abort period 6", per(6), 16);
    chk("abort period 7", per(7), 20);
    chk("abort done edge", done_n, 113);
    chk("abort position", int'(position_o), 9);
    // Abort in DIR_SETUP: back to IDLE with done, no step.
    run_move(5, 0, 10, 10, 0, 5, -1, 400);
    chk("setup abort done edge", done_n, 6);
    chk("setup abort no step", nr, 0);
    chk("setup abort position", int'(position_o), 9);
    @(negedge CLK);
    chk("setup abort busy", int'(busy_o), 0);
`else
    // Abort is ignored: the full 12-step ramp completes.
    run_move(12, 1, 8, 20, 4, 56, -1, 400);
    chk("no-abort step count", nr, 12);
    chk("no-abort period 9", per(9), 12);
    chk("no-abort done edge", done_n, 145);
    chk("no-abort position", int'(position_o), 13);
`endif

    // Reset in the middle of a long move.
    cif.cmd_valid = 1'b1; cif.cmd_steps = 16'd100; cif.cmd_dir = dir_o;
    cif.cmd_div = 16'd10; cif.cmd_start_div = 16'd10; cif.cmd_accel = '0;
    @(negedge CLK);
    cif.cmd_valid = 1'b0;
    repeat (25) @(negedge CLK);
    chk("midrun busy", int'(busy_o), 1);
    chk("midrun ready low", int'(cif.cmd_ready), 0);
    reset = 1'b1;
    @(negedge CLK);
    chk("midrun reset step", int'(step_o), 0);
    chk("midrun reset busy", int'(busy_o), 0);
    chk("midrun reset position", int'(position_o), 0);
    chk("midrun reset ready", int'(cif.cmd_ready), 1);
    chk("midrun reset dir", int'(dir_o), 0);
    reset = 1'b0;
    @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
